// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry and the writeback beat type.
package core_pkg;

    localparam int REG_INDX_W = 5;
    localparam int XLEN       = 32;

    localparam logic [REG_INDX_W-1:0] REG_ZERO = 5'd0;

    // One writeback beat as it travels from a requester to the register file.
    typedef struct packed {
        logic [REG_INDX_W-1:0] indx;
        logic [XLEN-1:0]       data;
    } wb_beat_t;

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Starvation tracker for the load/CSR writeback port.
// Counts consecutive cycles that port B waits while valid, saturates at
// STARVE_LIMIT, and raises force_b once the limit is reached so that the
// next B request wins regardless of port A.
module rf_wb_starve_ctr #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b_valid,
    input  logic             b_accept,
    output logic [CNT_W-1:0] starve_cnt,
    output logic             force_b
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    assign force_b = (starve_cnt == LIMIT);

    // Saturating wait counter: cleared by any B accept, held when B is idle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (b_accept) begin
            starve_cnt <= '0;
        end else if (b_valid && !force_b) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Port A (execute) normally wins; port B (load/CSR) is guaranteed progress by
// the starvation tracker. The winning beat is registered into one output stage
// that drives the register file and doubles as the decode forwarding source.
module rf_wb_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_indx,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_indx,
    input  logic [31:0] b_data,
    output logic        w_en,
    output logic [4:0]  w_indx,
    output logic [31:0] w_data,
    output logic        b_forced
);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_b;
    logic             accept_a;
    logic             accept_b;
    logic             accept_any;
    wb_beat_t         winner;

    rf_wb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .b_valid   (b_valid),
        .b_accept  (accept_b),
        .starve_cnt(starve_cnt),
        .force_b   (force_b)
    );

    // Grant decision: A has priority unless B has waited too long; nothing is
    // granted while reset is held so in-flight requests simply stay pending.
    // NOTE: every output gets a default before the branches so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (force_b) begin
                b_ready = 1'b1;
                a_ready = !b_valid;
            end else begin
                a_ready = 1'b1;
                b_ready = !a_valid;
            end
        end
    end

    assign b_forced   = force_b && b_valid;
    assign accept_a   = a_valid && a_ready;
    assign accept_b   = b_valid && b_ready;
    assign accept_any = accept_a || accept_b;

    // Select the beat of whichever port was accepted; grants are exclusive.
    always_comb begin
        winner = '{indx: a_indx, data: a_data};
        if (accept_b) begin
            winner = '{indx: b_indx, data: b_data};
        end
    end

    // Output stage: one-cycle write pulse; index/data hold between writes so
    // the forwarding path always sees the most recent committed beat. Writes
    // to x0 complete their handshake but never raise w_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en   <= 1'b0;
            w_indx <= '0;
            w_data <= '0;
        end else begin
            w_en <= accept_any && (winner.indx != REG_ZERO);
            if (accept_any && (winner.indx != REG_ZERO)) begin
                w_indx <= winner.indx;
                w_data <= winner.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus predicts each cycle's grants
// and the next output-stage contents; a monitor compares them after each edge.
module tb_rf_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_indx = '0, b_indx = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, w_en, b_forced;
    logic [4:0]  w_indx;
    logic [31:0] w_data;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_indx(a_indx), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_indx(b_indx), .b_data(b_data),
        .w_en(w_en), .w_indx(w_indx), .w_data(w_data), .b_forced(b_forced)
    );

    typedef struct {
        logic        en;
        logic [4:0]  indx;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: how long B has been waiting, and what the
    // register-file port last carried.
    int          m_wait = 0;
    logic [4:0]  m_indx = '0;
    logic [31:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of requests, check grants, predict the next output stage.
    task automatic cycle(input logic r, input logic av, input logic [4:0] ai, input logic [31:0] ad,
                         input logic bv, input logic [4:0] bi, input logic [31:0] bd,
                         output logic acc_a, output logic acc_b);
        bit   starved;
        bit   a_win;
        bit   b_win;
        exp_t e;
        @(negedge clk);
        rst = r; a_valid = av; a_indx = ai; a_data = ad;
        b_valid = bv; b_indx = bi; b_data = bd;
        #2;
        starved = (m_wait == LIMIT);
        b_win   = !r && bv && (starved || !av);
        a_win   = !r && av && !b_win;
        check("a_ready", a_ready, !r && !(starved && bv));
        check("b_ready", b_ready, !r && (starved || !av));
        check("b_forced", b_forced, starved && bv);
        acc_a = a_win;
        acc_b = b_win;
        e.en = 1'b0;
        if (r) begin
            m_wait = 0;
            m_indx = '0;
            m_data = '0;
        end else begin
            if (b_win)   m_wait = 0;
            else if (bv) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
            if (a_win && ai != 5'd0) begin
                e.en = 1'b1; m_indx = ai; m_data = ad;
            end else if (b_win && bi != 5'd0) begin
                e.en = 1'b1; m_indx = bi; m_data = bd;
            end
        end
        e.indx = m_indx;
        e.data = m_data;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        logic x, y;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x, y);
    endtask

    // Monitor: the output stage presents a beat every cycle; compare after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("w_en", w_en, e.en);
                check("w_indx", w_indx, e.indx);
                check("w_data", w_data, e.data);
            end
        end
    end

    initial begin
        logic        aa, ab;
        logic        bv_hold;
        logic        r_av, r_bv, a_hold, b_hold, r_rst;
        logic [4:0]  r_ai, r_bi;
        logic [31:0] r_ad, r_bd;

        // Reset state.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, ab);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, ab);

        // A only.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, aa, ab);
        idle(2);

        // Collision, then B takes its turn.
        cycle(1'b0, 1'b1, 5'd3, 32'h0000_3333, 1'b1, 5'd7, 32'h0000_7777, aa, ab);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_7777, aa, ab);
        idle(2);

        // Starvation: A saturates the port until B is forced through.
        bv_hold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, 5'(10 + i), 32'hA000_0000 + i, bv_hold, 5'd12, 32'hB0B0_0012, aa, ab);
            if (ab) bv_hold = 1'b0;
        end
        idle(1);

        // Write to x0 is dropped but the handshake completes.
        cycle(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, aa, ab);
        idle(1);

        // Back-to-back A writes.
        for (int i = 1; i <= 3; i++)
            cycle(1'b0, 1'b1, 5'(i), 32'hC000_0000 + i, 1'b0, 5'd0, 32'd0, aa, ab);
        idle(1);

        // Reset mid-operation: request held through reset, accepted afterwards.
        cycle(1'b0, 1'b1, 5'd4, 32'h0000_4444, 1'b0, 5'd0, 32'd0, aa, ab);
        cycle(1'b1, 1'b1, 5'd9, 32'h0000_9999, 1'b0, 5'd0, 32'd0, aa, ab);
        cycle(1'b0, 1'b1, 5'd9, 32'h0000_9999, 1'b0, 5'd0, 32'd0, aa, ab);
        idle(2);

        // Randomized traffic; requesters hold their beat until accepted.
        a_hold = 1'b0; b_hold = 1'b0;
        r_av = 1'b0; r_bv = 1'b0; r_ai = '0; r_bi = '0; r_ad = '0; r_bd = '0;
        for (int i = 0; i < 800; i++) begin
            if (!a_hold) begin
                r_av = ((i / 100) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                r_ai = 5'($urandom_range(0, 31));
                r_ad = $urandom;
            end
            if (!b_hold) begin
                r_bv = ($urandom_range(0, 1) == 0);
                r_bi = 5'($urandom_range(0, 31));
                r_bd = $urandom;
            end
            r_rst = ($urandom_range(0, 99) == 0);
            cycle(r_rst, r_av, r_ai, r_ad, r_bv, r_bi, r_bd, aa, ab);
            a_hold = r_av && !aa;
            b_hold = r_bv && !ab;
        end

        idle(3);
        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
